// File: rtl/lcg_prng_gen.sv
// LCG pseudo-random generator feeding a small output FIFO.
// Ports: clk, rst (async, active-low), enable, seed_valid/seed, out_valid/out_ready/out_data, level.
module lcg_prng_gen #(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] MULT         = 64'h5851F42D4C957F2D,
  parameter logic [WIDTH-1:0] INC          = 64'h14057B7EF767814F,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = '0,
  parameter int               OUT_MODE     = 0,
  parameter int               DEPTH        = 4,
  localparam int              AW           = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      level
);

  localparam int        HALF = WIDTH / 2;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop;
  logic             gen;

  // Only the low WIDTH bits of the product are kept by the context width.
  assign next_state = state * MULT + INC;

  assign word = (OUT_MODE == 1) ? (state ^ (state >> HALF)) : state;

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // A seed load overrides both pop and generate on the same edge.
  assign pop = out_valid & out_ready & ~seed_valid;
  assign gen = enable & ~seed_valid & ((level < FULL) | pop);

  always_ff @(posedge clk) begin
    if (gen)
      mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= SEED_DEFAULT;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (seed_valid) begin
      state  <= seed;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (gen) begin
        state  <= next_state;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({gen, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_lcg_prng_gen.sv
// Directed self-checking bench for lcg_prng_gen.
// Raw-output and folded-output instances share one stimulus stream.
module tb_lcg_prng_gen;

  localparam logic [63:0] M = 64'h5851F42D4C957F2D;
  localparam logic [63:0] I = 64'h14057B7EF767814F;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        seed_valid;
  logic [63:0] seed;
  logic        out_ready;
  logic        v0, v1;
  logic [63:0] d0, d1;
  logic [2:0]  l0, l1;

  int errors = 0;
  int checks = 0;

  lcg_prng_gen u0 (
    .clk(clk), .rst(rst), .enable(enable),
    .seed_valid(seed_valid), .seed(seed),
    .out_valid(v0), .out_ready(out_ready),
    .out_data(d0), .level(l0)
  );

  lcg_prng_gen #(.OUT_MODE(1)) u1 (
    .clk(clk), .rst(rst), .enable(enable),
    .seed_valid(seed_valid), .seed(seed),
    .out_valid(v1), .out_ready(out_ready),
    .out_data(d1), .level(l1)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lcg(input logic [63:0] s);
    return s * M + I;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] e;

  initial begin
    rst        = 1'b0;
    enable     = 1'b0;
    seed_valid = 1'b0;
    seed       = '0;
    out_ready  = 1'b0;
    #3;
    chk("rst_valid", 64'(v0), 64'd0);
    chk("rst_level", 64'(l0), 64'd0);
    chk("rst_data",  d0,      64'd0);
    step();
    step();
    rst = 1'b1;

    // Default seed stream
    enable    = 1'b1;
    out_ready = 1'b1;
    step();
    chk("w0_valid", 64'(v0), 64'd1);
    chk("w0_level", 64'(l0), 64'd1);
    chk("w0_data",  d0,      64'h0);
    chk("w0_fold",  d1,      64'h0);
    step();
    chk("w1_data",  d0,      64'h14057B7EF767814F);
    chk("w1_fold",  d1,      64'h14057B7EE362FA31);
    chk("w1_level", 64'(l0), 64'd1);
    enable = 1'b0;
    step();
    chk("drain_level", 64'(l0), 64'd0);
    chk("drain_valid", 64'(v0), 64'd0);
    chk("drain_data",  d0,      64'd0);

    // Seed load to 1
    seed_valid = 1'b1;
    seed       = 64'd1;
    enable     = 1'b1;
    step();
    seed_valid = 1'b0;
    chk("seed1_level", 64'(l0), 64'd0);
    step();
    chk("s1_w0", d0, 64'h1);
    chk("s1_f0", d1, 64'h1);
    step();
    chk("s1_w1", d0, 64'h6C576FAC43FD007C);
    chk("s1_f1", d1, 64'h6C576FAC2FAA6FD0);
    enable = 1'b0;
    step();

    // Backpressure: fill to DEPTH and saturate
    seed_valid = 1'b1;
    seed       = 64'd0;
    out_ready  = 1'b0;
    step();
    seed_valid = 1'b0;
    enable     = 1'b1;
    step();
    chk("bp_l1", 64'(l0), 64'd1);
    step();
    chk("bp_l2", 64'(l0), 64'd2);
    step();
    step();
    chk("bp_l4", 64'(l0), 64'd4);
    step();
    step();
    chk("bp_sat",   64'(l0), 64'd4);
    chk("bp_head",  d0,      64'd0);
    chk("bp_valid", 64'(v0), 64'd1);
    out_ready = 1'b1;
    e = 64'd0;
    for (int k = 1; k <= 8; k++) begin
      step();
      e = lcg(e);
      chk($sformatf("stream%0d", k), d0, e);
      chk($sformatf("stream_lvl%0d", k), 64'(l0), 64'd4);
    end

    // Seed load while full and popping
    out_ready = 1'b0;
    step();
    chk("full_again", 64'(l0), 64'd4);
    seed_valid = 1'b1;
    seed       = 64'h0123456789ABCDEF;
    out_ready  = 1'b1;
    step();
    seed_valid = 1'b0;
    chk("flush_level", 64'(l0), 64'd0);
    chk("flush_valid", 64'(v0), 64'd0);
    step();
    chk("ns_w0",  d0,      64'h0123456789ABCDEF);
    chk("ns_lvl", 64'(l0), 64'd1);
    step();
    chk("ns_w1",  d0,      lcg(64'h0123456789ABCDEF));

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", 64'(v0), 64'd0);
    chk("async_level", 64'(l0), 64'd0);
    chk("async_data",  d0,      64'd0);
    #1;
    rst = 1'b1;
    step();
    chk("rs_w0", d0, 64'h0);
    step();
    chk("rs_w1", d0, 64'h14057B7EF767814F);
    chk("rs_f1", d1, 64'h14057B7EE362FA31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcg_prng_gen.md
LCG_PRNG_GEN -- requirements
Module: lcg_prng_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 64: state and output width in bits (even, at least 16).
REQ-002 SHALL have parameter MULT, default 64'h5851F42D4C957F2D: LCG multiplier, truncated to WIDTH.
REQ-003 SHALL have parameter INC, default 64'h14057B7EF767814F: LCG increment, truncated to WIDTH.
REQ-004 SHALL have parameter SEED_DEFAULT, default 0: state value loaded at reset.
REQ-005 SHALL have parameter OUT_MODE, default 0: 0 = raw state output, 1 = xorshift-folded output.
REQ-006 SHALL have parameter DEPTH, default 4: output FIFO depth (power of two, at least 2).
REQ-007 clk  input  1  clock; all logic is rising-edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 enable  input  1  high permits generation.
REQ-010 seed_valid  input  1  one-cycle request to load seed.
REQ-011 seed  input  WIDTH  new state value.
REQ-012 out_valid  output  1  FIFO non-empty.
REQ-013 out_ready  input  1  consumer accepts the head word.
REQ-014 out_data  output  WIDTH  FIFO head word.
REQ-015 level  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 Next-state SHALL be (state*MULT + INC) mod 2^WIDTH; only the low WIDTH product bits are used.
REQ-017 Output function f(s) SHALL be s for OUT_MODE=0 and s ^ (s >> WIDTH/2) for OUT_MODE=1.
REQ-018 Generate condition: enable=1, seed_valid=0, and (level<DEPTH, or a pop occurs in the same cycle).
REQ-019 On a generate edge, f(current state) SHALL be pushed and state SHALL advance per REQ-016 on the same edge.
REQ-020 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; the head entry is removed.
REQ-021 Push and pop on the same edge SHALL leave level unchanged and preserve word order.
REQ-022 out_valid SHALL be high exactly when level>0.
REQ-023 out_data SHALL equal the head entry when out_valid=1 and SHALL be 0 when the FIFO is empty.
REQ-024 Latency: the first word SHALL be visible on out_valid/out_data immediately after the first generate edge.
REQ-025 When full with no pop, state SHALL hold and no word SHALL be lost or duplicated.
REQ-026 With enable=0, state SHALL hold; the existing FIFO contents SHALL remain poppable.
REQ-027 seed_valid=1 SHALL load state<=seed and flush the FIFO (level<=0) on that edge.
REQ-028 seed_valid=1 SHALL take priority over a simultaneous pop or generate; neither takes effect.
REQ-029 After a seed load, the first word pushed SHALL be f(seed).
REQ-030 FIFO pointers SHALL wrap modulo DEPTH; level SHALL range over 0..DEPTH only.
REQ-031 Emitted words SHALL follow the exact LCG sequence from the last load, with no gaps or repeats across stalls.

Reset
REQ-032 While rst=0: state=SEED_DEFAULT, FIFO empty, level=0, out_valid=0, out_data=0.
REQ-033 Reset asserted mid-operation SHALL discard all FIFO contents immediately, regardless of clk.
REQ-034 After rst deasserts, the first generate edge SHALL push f(SEED_DEFAULT).

Verification
REQ-035 Defaults, reset, then enable=1, out_ready=1 -> words 0x0000000000000000, 0x14057B7EF767814F in order.
REQ-036 seed_valid pulse with seed=1, then run -> words 0x0000000000000001, 0x6C576FAC43FD007C.
REQ-037 OUT_MODE=1, seed=0, run -> second word 0x14057B7EE362FA31.
REQ-038 out_ready=0 with enable=1 -> level saturates at 4 and out_data holds 0; release out_ready -> contiguous sequence, no gaps.
REQ-039 seed_valid on the same edge as a pop while full -> level=0 and out_valid=0 next cycle; the next word is f(seed).
REQ-040 rst pulsed low between clock edges mid-stream -> out_valid=0 and level=0 at once; the sequence restarts from SEED_DEFAULT.
